// File: rtl/beta_imem_rsp_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encoding,
// counter sizing and the data value returned on a faulting fetch.
package beta_imem_rsp_pkg;

    typedef enum logic [2:0] {
        RSP_IDLE   = 3'd0,
        RSP_STALL  = 3'd1,
        RSP_ACCEPT = 3'd2,
        RSP_WAIT   = 3'd3,
        RSP_VALID  = 3'd4
    } imem_rsp_state_t;

    localparam int unsigned IMEM_CNT_W             = 4;
    localparam int unsigned IMEM_MAX_READY_DELAY   = 15;
    localparam int unsigned IMEM_MAX_RESP_LATENCY  = 15;
    localparam int unsigned IMEM_MIN_XACT_CYCLES   = 3;

    localparam logic [31:0] IMEM_ERR_DATA = 32'h00000000;

endpackage

// File: rtl/beta_imem_array.sv
// 1R1W synchronous instruction RAM. Registered read; a same-edge write to the
// read word returns the old contents. Storage itself is never reset.
module beta_imem_array #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MemDepth  = 1024,
    parameter int unsigned IdxWidth  = (MemDepth > 1) ? $clog2(MemDepth) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [IdxWidth-1:0]  wr_idx,
    input  logic [DataWidth-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [IdxWidth-1:0]  rd_idx,
    input  logic                 rd_force,
    input  logic [DataWidth-1:0] rd_force_data,
    output logic [DataWidth-1:0] rd_data
);

    logic [DataWidth-1:0] mem [MemDepth];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Forced reads (faulting fetches) bypass the storage entirely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_force ? rd_force_data : mem[rd_idx];
        end
    end

endmodule

// File: rtl/beta_imem_responder.sv
// Fetch-side responder: accepts one request at a time, inserts the configured
// ready/valid delays and returns the addressed word or an access error.
module beta_imem_responder
    import beta_imem_rsp_pkg::*;
#(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned MemDepth    = 1024,
    parameter int unsigned ReadyDelay  = 0,
    parameter int unsigned RespLatency = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 imem_req_i,
    input  logic [AddrWidth-1:0] imem_addr_i,
    output logic                 imem_ready_o,
    output logic                 imem_valid_o,
    output logic [DataWidth-1:0] imem_rdata_o,
    output logic                 imem_err_o,
    input  logic                 imem_wr_en_i,
    input  logic [AddrWidth-1:0] imem_wr_addr_i,
    input  logic [DataWidth-1:0] imem_wr_data_i
);

    localparam int unsigned IdxWidth = (MemDepth > 1) ? $clog2(MemDepth) : 1;

    localparam logic [IMEM_CNT_W-1:0] StallLast = IMEM_CNT_W'(ReadyDelay - 1);
    localparam logic [IMEM_CNT_W-1:0] WaitLast  = IMEM_CNT_W'(RespLatency - 2);

    imem_rsp_state_t       state_q, state_d;
    logic [IMEM_CNT_W-1:0] cnt_q, cnt_d;
    logic [IdxWidth-1:0]   idx_q;
    logic                  bad_q;
    logic                  latch;
    logic                  req_bad;
    logic                  wr_bad;

    // Misaligned or beyond-the-array byte addresses are faults.
    function automatic logic addr_bad(input logic [AddrWidth-1:0] a);
        return (a[1:0] != 2'b00) ||
               (a[AddrWidth-1:2] >= (AddrWidth-2)'(MemDepth));
    endfunction

    assign req_bad = addr_bad(imem_addr_i);
    assign wr_bad  = addr_bad(imem_wr_addr_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RSP_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        case (state_q)
            RSP_IDLE: begin
                if (imem_req_i) begin
                    latch   = 1'b1;
                    cnt_d   = '0;
                    state_d = (ReadyDelay > 0) ? RSP_STALL : RSP_ACCEPT;
                end
            end
            RSP_STALL: begin
                if (cnt_q == StallLast) begin
                    cnt_d   = '0;
                    state_d = RSP_ACCEPT;
                end else begin
                    cnt_d = IMEM_CNT_W'(cnt_q + 1'b1);
                end
            end
            RSP_ACCEPT: begin
                cnt_d   = '0;
                state_d = (RespLatency > 1) ? RSP_WAIT : RSP_VALID;
            end
            RSP_WAIT: begin
                if (cnt_q == WaitLast) begin
                    cnt_d   = '0;
                    state_d = RSP_VALID;
                end else begin
                    cnt_d = IMEM_CNT_W'(cnt_q + 1'b1);
                end
            end
            RSP_VALID: begin
                state_d = RSP_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = RSP_IDLE;
            end
        endcase
    end

    // Address and its fault status are frozen for the whole transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q <= '0;
            bad_q <= 1'b0;
        end else if (latch) begin
            idx_q <= IdxWidth'(imem_addr_i[AddrWidth-1:2]);
            bad_q <= req_bad;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            imem_ready_o <= 1'b0;
            imem_valid_o <= 1'b0;
            imem_err_o   <= 1'b0;
        end else begin
            imem_ready_o <= (state_d == RSP_ACCEPT);
            imem_valid_o <= (state_d == RSP_VALID);
            imem_err_o   <= (state_d == RSP_VALID) && bad_q;
        end
    end

    beta_imem_array #(
        .DataWidth (DataWidth),
        .MemDepth  (MemDepth),
        .IdxWidth  (IdxWidth)
    ) u_array (
        .clk           (clk_i),
        .rst           (rst_i),
        .wr_en         (imem_wr_en_i && !wr_bad),
        .wr_idx        (IdxWidth'(imem_wr_addr_i[AddrWidth-1:2])),
        .wr_data       (imem_wr_data_i),
        .rd_en         (state_d == RSP_VALID),
        .rd_idx        (idx_q),
        .rd_force      (bad_q),
        .rd_force_data (DataWidth'(IMEM_ERR_DATA)),
        .rd_data       (imem_rdata_o)
    );

endmodule

// File: tb/tb_beta_imem_responder.sv
// Scoreboard bench for beta_imem_responder: one default-timing instance and
// one slow instance (ReadyDelay=3, RespLatency=4) share clock and reset.
module tb_beta_imem_responder;

    logic        clk;
    logic        rst;
    logic        req     [2];
    logic [31:0] addr    [2];
    logic        ready   [2];
    logic        valid   [2];
    logic [31:0] rdata   [2];
    logic        err     [2];
    logic        wr_en   [2];
    logic [31:0] wr_addr [2];
    logic [31:0] wr_data [2];

    logic [32:0] q0[$];
    logic [32:0] q1[$];
    int rdy_cnt [2];
    int vld_cnt [2];
    int errors = 0;
    int checks = 0;

    beta_imem_responder u_dut0 (
        .clk_i(clk), .rst_i(rst),
        .imem_req_i(req[0]), .imem_addr_i(addr[0]),
        .imem_ready_o(ready[0]), .imem_valid_o(valid[0]),
        .imem_rdata_o(rdata[0]), .imem_err_o(err[0]),
        .imem_wr_en_i(wr_en[0]), .imem_wr_addr_i(wr_addr[0]),
        .imem_wr_data_i(wr_data[0])
    );

    beta_imem_responder #(.ReadyDelay(3), .RespLatency(4)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .imem_req_i(req[1]), .imem_addr_i(addr[1]),
        .imem_ready_o(ready[1]), .imem_valid_o(valid[1]),
        .imem_rdata_o(rdata[1]), .imem_err_o(err[1]),
        .imem_wr_en_i(wr_en[1]), .imem_wr_addr_i(wr_addr[1]),
        .imem_wr_data_i(wr_data[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents valid data.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [32:0] e;
            logic        empty;
            if (ready[d]) rdy_cnt[d]++;
            if (ready[d] && valid[d]) chk("ready_valid_overlap", d, 32'd1, 32'd0);
            if (valid[d]) begin
                vld_cnt[d]++;
                empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
                if (empty) begin
                    chk("unexpected_valid", d, 32'd1, 32'd0);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk("rdata", d, rdata[d], e[31:0]);
                    chk("err", d, 32'(err[d]), 32'(e[32]));
                end
            end
        end
    end

    task automatic wr(input int d, input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        wr_en[d] = 1'b1; wr_addr[d] = a; wr_data[d] = v;
        @(negedge clk);
        wr_en[d] = 1'b0;
    endtask

    task automatic xact(input int d, input logic [31:0] a, input logic [31:0] ed,
                        input logic ee, input int er, input int ev,
                        input logic hold, input logic [31:0] alt,
                        input logic col, input logic [31:0] cdata);
        int n, m, r0, v0;
        @(negedge clk);
        r0 = rdy_cnt[d];
        v0 = vld_cnt[d];
        req[d] = 1'b1;
        addr[d] = a;
        if (d == 0) q0.push_back({ee, ed}); else q1.push_back({ee, ed});
        n = 0;
        do begin @(negedge clk); n++; end while (!ready[d] && n < 40);
        chk("ready_latency", d, 32'(n), 32'(er));
        if (!hold) req[d] = 1'b0;
        if (col) begin
            wr_en[d] = 1'b1; wr_addr[d] = a; wr_data[d] = cdata;
        end
        m = 0;
        do begin
            @(negedge clk);
            m++;
            wr_en[d] = 1'b0;
            if (hold && m == 1) addr[d] = alt;
        end while (!valid[d] && m < 40);
        req[d] = 1'b0;
        chk("valid_latency", d, 32'(m), 32'(ev));
        @(negedge clk);
        chk("ready_pulses", d, 32'(rdy_cnt[d] - r0), 32'd1);
        chk("valid_pulses", d, 32'(vld_cnt[d] - v0), 32'd1);
    endtask

    initial begin
        int n, r0, v0;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; addr[d] = '0; wr_en[d] = 1'b0;
            wr_addr[d] = '0; wr_data[d] = '0;
            rdy_cnt[d] = 0; vld_cnt[d] = 0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", d, 32'(ready[d]), 32'd0);
            chk("reset_valid", d, 32'(valid[d]), 32'd0);
            chk("reset_err", d, 32'(err[d]), 32'd0);
            chk("reset_rdata", d, rdata[d], 32'h0);
        end
        rst = 1'b0;

        for (int d = 0; d < 2; d++) begin
            wr(d, 32'h0, 32'h00500093);
            wr(d, 32'h4, 32'h00A00113);
        end
        // Dropped writes that would alias word 0 if decoded carelessly.
        wr(0, 32'h0000_1000, 32'h1111_1111);
        wr(0, 32'h0000_0002, 32'h2222_2222);

        xact(0, 32'h4, 32'h00A00113, 1'b0, 1, 1, 1'b0, '0, 1'b0, '0);
        xact(1, 32'h0, 32'h00500093, 1'b0, 4, 4, 1'b0, '0, 1'b0, '0);

        xact(0, 32'h6,    32'h0, 1'b1, 1, 1, 1'b0, '0, 1'b0, '0);
        xact(0, 32'h1000, 32'h0, 1'b1, 1, 1, 1'b0, '0, 1'b0, '0);
        xact(1, 32'h6,    32'h0, 1'b1, 4, 4, 1'b0, '0, 1'b0, '0);
        xact(0, 32'h0, 32'h00500093, 1'b0, 1, 1, 1'b0, '0, 1'b0, '0);
        xact(0, 32'h4, 32'h00A00113, 1'b0, 1, 1, 1'b0, '0, 1'b0, '0);

        // Same-edge write is invisible; the next fetch sees it.
        xact(0, 32'h4, 32'h00A00113, 1'b0, 1, 1, 1'b0, '0, 1'b1, 32'hDEADBEEF);
        xact(0, 32'h4, 32'hDEADBEEF, 1'b0, 1, 1, 1'b0, '0, 1'b0, '0);

        // Held request with address change during the wait phase.
        xact(1, 32'h4, 32'h00A00113, 1'b0, 4, 4, 1'b1, 32'h0, 1'b0, '0);
        r0 = rdy_cnt[1];
        repeat (8) @(negedge clk);
        chk("no_spurious_accept", 1, 32'(rdy_cnt[1] - r0), 32'd0);

        // Abort a slow transaction in its wait phase.
        @(negedge clk);
        req[1] = 1'b1; addr[1] = 32'h4;
        n = 0;
        do begin @(negedge clk); n++; end while (!ready[1] && n < 40);
        chk("abort_ready_latency", 1, 32'(n), 32'd4);
        req[1] = 1'b0;
        v0 = vld_cnt[1];
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_ready_low", 1, 32'(ready[1]), 32'd0);
        chk("abort_valid_low", 1, 32'(valid[1]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("no_valid_after_abort", 1, 32'(vld_cnt[1] - v0), 32'd0);

        xact(0, 32'h4, 32'hDEADBEEF, 1'b0, 1, 1, 1'b0, '0, 1'b0, '0);
        xact(1, 32'h0, 32'h00500093, 1'b0, 4, 4, 1'b0, '0, 1'b0, '0);

        chk("scoreboard_drained", 0, 32'(q0.size()), 32'd0);
        chk("scoreboard_drained", 1, 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/beta_imem_responder.md
# beta_imem_responder

Instruction-memory responder for the fetch interface: it answers the fetch unit's request/ready/valid protocol from a word-addressed on-chip instruction array. It sits between the IF-stage fetch unit and the instruction storage. It is the standard imem model for simulation benches and for TCM-style synthesis targets. Response timing is parameterisable so the fetch path can be exercised under slow-memory conditions.

## Interface
Parameters:
- DataWidth, 32, width of an instruction word (32 only in v0.1)
- AddrWidth, 32, width of the byte address
- MemDepth, 1024, number of words in the array
- ReadyDelay, 0, idle cycles inserted between sampling the request and asserting ready (0..15)
- RespLatency, 1, cycles from the ready pulse to the valid pulse (1..15)

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- imem_req_i  in  1  fetch request, held by the initiator until ready is seen
- imem_addr_i  in  AddrWidth  byte address, valid while imem_req_i=1
- imem_ready_o  out  1  request accepted, one-cycle pulse
- imem_valid_o  out  1  read data valid, one-cycle pulse
- imem_rdata_o  out  DataWidth  read data, meaningful only while imem_valid_o=1
- imem_err_o  out  1  access error, asserted together with imem_valid_o
- imem_wr_en_i  in  1  preload/patch write enable
- imem_wr_addr_i  in  AddrWidth  preload byte address, word-aligned
- imem_wr_data_i  in  DataWidth  preload data

## Operation
- FSM states and transitions:
  - RSP_IDLE: on imem_req_i=1, latch imem_addr_i. Go to RSP_STALL if ReadyDelay>0, else to RSP_ACCEPT.
  - RSP_STALL: count ReadyDelay cycles, then go to RSP_ACCEPT.
  - RSP_ACCEPT: imem_ready_o=1 for exactly this cycle. Go to RSP_WAIT if RespLatency>1, else to RSP_VALID.
  - RSP_WAIT: count RespLatency-1 cycles, then go to RSP_VALID.
  - RSP_VALID: imem_valid_o=1 and imem_rdata_o driven for exactly this cycle. Return to RSP_IDLE.
- Request handling outside RSP_IDLE:
  - imem_req_i is ignored in every state other than RSP_IDLE. No queuing.
  - The latched address is used for the whole transaction; changes on imem_addr_i after latching have no effect.
- Address decode:
  - Word index is addr[AddrWidth-1:2].
  - An access is an error when addr[1:0]!=0 or index>=MemDepth. The error condition is latched with the address.
  - On error: imem_rdata_o=32'h00000000 and imem_err_o=1 in RSP_VALID. The array is not read.
- Write port:
  - A synchronous write occurs on any cycle with imem_wr_en_i=1, independent of FSM state.
  - Misaligned or out-of-range write addresses are dropped silently.
- Read data:
  - Array data is registered on the edge that enters RSP_VALID.
  - A write to the same word on that same edge is not visible: the read returns the old data.
  - A write on any earlier cycle of the transaction is visible.
- Array contents are not reset.

## Timing
- Reset values: imem_ready_o=0, imem_valid_o=0, imem_err_o=0, imem_rdata_o=0, state RSP_IDLE, counters 0.
- All outputs are registered; there is no combinational path from input to output.
- Default parameters: request sampled at edge E1, ready high in cycle E1–E2, valid high in cycle E2–E3. The initiator captures data at E3.
- General case: ready asserts 1+ReadyDelay cycles after the edge that samples the request. Valid asserts RespLatency cycles after ready.
- Back-to-back: the next request can be sampled on the first RSP_IDLE cycle after RSP_VALID. Minimum of 3 cycles per transaction.
- Reset mid-transaction: the transaction is aborted immediately and asynchronously. Ready and valid drop to 0 and no valid is produced after release.
- ready and valid are never high in the same cycle.

## Structure
- Shared package beta_imem_rsp_pkg holds:
  - the FSM state encoding (imem_rsp_state_t, 3-bit), alongside the existing imem FSM constants;
  - the counter width constant;
  - IMEM_ERR_DATA = 32'h00000000.
- Sub-module beta_imem_array:
  - 1R1W synchronous RAM with parameters DataWidth and MemDepth;
  - registered read, read-before-write on address collision.
- The FSM, counters, address decode and error logic stay in beta_imem_responder.

## Test plan
- Preload word 0x0 = 0x00500093 and word 0x4 = 0x00A00113. With default parameters, request addr 0x4 at E1 -> ready in cycle 2, valid in cycle 3, rdata=0x00A00113, err=0.
- ReadyDelay=3, RespLatency=4, request addr 0x0 -> ready exactly 4 cycles after sampling, valid exactly 4 cycles after ready, rdata=0x00500093.
- Request addr 0x6 -> valid with rdata=0, err=1. Request addr 4*MemDepth -> valid with rdata=0, err=1. The array is unchanged in both cases.
- Collision: during a transaction to 0x4, write 0xDEADBEEF to 0x4 on the RSP_VALID entry edge -> rdata=0x00A00113. Repeat the request -> rdata=0xDEADBEEF.
- Hold req high and change addr while in RSP_WAIT -> the original address's data is returned, exactly one ready and one valid per accepted request, and there is no spurious second accept.
- Assert rst_i asynchronously during RSP_WAIT -> ready and valid go low at once, no valid after release, and the next request completes normally with default timing.
